// File: rtl/phys_mem_responder_pkg.sv
// Shared encodings for the physical memory responder.
// Sizes, FSM states, counter width and LFSR seed.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // Holds LATENCY-1 (max 14) plus up to 3 jitter cycles.
    localparam int unsigned CNT_W = 5;

    localparam logic [3:0] LFSR_SEED = 4'b1001;

endpackage

// File: rtl/phys_mem_responder_if.sv
// Data-side memory request/response bundle.
// master = core side, slave = responder side.
interface phys_mem_responder_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata, err
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata, err
    );
endinterface

// File: rtl/phys_mem_responder_byte_en_ram.sv
// Word array with per-byte write enables and asynchronous read.
// Contents are deliberately not reset.
module byte_en_ram #(
    parameter int unsigned WORDS = 1024
) (
    input  logic                     clk,
    input  logic [3:0]               i_we,
    input  logic [$clog2(WORDS)-1:0] i_addr,
    input  logic [31:0]              i_wdata,
    output logic [31:0]              o_rdata
);
    logic [31:0] r_mem [WORDS];

    // Byte-lane write; lanes without an enable keep their value.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (i_we[i]) begin
                r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/phys_mem_responder.sv
// Physically addressed memory responder, one transaction outstanding.
// Optional response jitter: define MEM_RESP_JITTER_EN.
module phys_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    phys_mem_responder_if.slave  bus
);
    localparam int unsigned AW = $clog2(MEM_WORDS);

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_wr;
    logic             r_txn_err;
    logic [AW-1:0]    r_idx;
    logic [3:0]       r_wstrb;
    logic [31:0]      r_wdata;
    logic             r_addr_ok;
    logic             r_data_ok;
    logic [31:0]      r_rdata;
    logic             r_err;

    logic [31:0]      w_off;
    logic             w_err;
    logic             w_hs;
    logic [CNT_W-1:0] w_jit;
    logic [CNT_W-1:0] w_load;
    logic             w_idle;
    logic             w_enter;
    logic             w_c_wr;
    logic             w_c_err;
    logic [AW-1:0]    w_c_idx;
    logic [3:0]       w_c_wstrb;
    logic [31:0]      w_c_wdata;
    logic [3:0]       w_we;
    logic [31:0]      w_ram_rdata;

    assign w_off  = bus.addr - BASE_ADDR;
    assign w_idle = (r_state == S_IDLE);
    assign w_hs   = bus.req & r_addr_ok & w_idle;

    // Alignment, size and range checks on the incoming request.
    always_comb begin
        w_err = 1'b0;
        case (bus.size)
            SZ_BYTE: w_err = 1'b0;
            SZ_HALF: w_err = w_off[0];
            SZ_WORD: w_err = |w_off[1:0];
            default: w_err = 1'b1;
        endcase
        if (|w_off[31:AW+2]) begin
            w_err = 1'b1;
        end
    end

`ifdef MEM_RESP_JITTER_EN
    logic [3:0] r_lfsr;

    // x^4+x^3+1 LFSR, free-running; low two bits pick extra wait cycles.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
        end
    end

    assign w_jit = {{(CNT_W-2){1'b0}}, r_lfsr[1:0]};
`else
    assign w_jit = '0;
`endif

    assign w_load = CNT_W'(LATENCY - 1) + w_jit;

    // In IDLE the transaction is still on the bus; later it is latched.
    assign w_c_wr    = w_idle ? bus.wr             : r_wr;
    assign w_c_err   = w_idle ? w_err              : r_txn_err;
    assign w_c_idx   = w_idle ? w_off[AW+1:2]      : r_idx;
    assign w_c_wstrb = w_idle ? bus.wstrb          : r_wstrb;
    assign w_c_wdata = w_idle ? bus.wdata          : r_wdata;

    // Commit point: the edge that moves the FSM into RESP.
    assign w_enter = (w_hs && (w_load == '0))
                   || ((r_state == S_WAIT) && (r_cnt == CNT_W'(1)));

    assign w_we = (w_enter && resetn && w_c_wr && !w_c_err)
                ? w_c_wstrb : 4'b0000;

    byte_en_ram #(
        .WORDS (MEM_WORDS)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_c_idx),
        .i_wdata (w_c_wdata),
        .o_rdata (w_ram_rdata)
    );

    // Request FSM with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_wr      <= 1'b0;
            r_txn_err <= 1'b0;
            r_idx     <= '0;
            r_wstrb   <= 4'b0000;
            r_wdata   <= 32'h0;
            r_addr_ok <= 1'b0;
            r_data_ok <= 1'b0;
            r_rdata   <= 32'h0;
            r_err     <= 1'b0;
        end else begin
            r_data_ok <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_wr      <= bus.wr;
                        r_txn_err <= w_err;
                        r_idx     <= w_off[AW+1:2];
                        r_wstrb   <= bus.wstrb;
                        r_wdata   <= bus.wdata;
                        r_cnt     <= w_load;
                        r_addr_ok <= 1'b0;
                        r_state   <= (w_load == '0) ? S_RESP : S_WAIT;
                    end else begin
                        r_addr_ok <= 1'b1;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state   <= S_IDLE;
                    r_addr_ok <= 1'b1;
                    r_rdata   <= 32'h0;
                    r_err     <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
            if (w_enter) begin
                r_data_ok <= 1'b1;
                r_err     <= w_c_err;
                r_rdata   <= (w_c_wr || w_c_err) ? 32'h0 : w_ram_rdata;
            end
        end
    end

    assign bus.addr_ok = r_addr_ok;
    assign bus.data_ok = r_data_ok;
    assign bus.rdata   = r_rdata;
    assign bus.err     = r_err;
endmodule

// File: tb/tb_phys_mem_responder.sv
// Self-checking bench for phys_mem_responder (random ops vs word-array model).
// Honours MEM_RESP_JITTER_EN the same way as the design.
module tb_phys_mem_responder;
    localparam int          LAT   = 2;
    localparam int          WORDS = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic [3:0]  m_lfsr = 4'b1001;
    logic [31:0] m_mem [WORDS];

    phys_mem_responder_if bus ();

    phys_mem_responder #(
        .MEM_WORDS (WORDS),
        .BASE_ADDR (BASE),
        .LATENCY   (LAT)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Cycle counter and model of the x^4+x^3+1 jitter sequence.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!resetn) m_lfsr <= 4'b1001;
        else m_lfsr <= {m_lfsr[2:0], m_lfsr[3] ^ m_lfsr[2]};
    end

    function automatic int exp_jit(input logic [3:0] l);
`ifdef MEM_RESP_JITTER_EN
        return int'(l % 4);
`else
        return 0 * int'(l);
`endif
    endfunction

    function automatic logic ref_err(input int sz, input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (sz == 3) return 1'b1;
        if (sz == 1 && (a % 2) != 0) return 1'b1;
        if (sz == 2 && (a % 4) != 0) return 1'b1;
        if (off >= WORDS * 4) return 1'b1;
        return 1'b0;
    endfunction

    // Issue one request (called at a negedge); returns response and timing.
    task automatic do_txn(input logic w, input int sz, input logic [31:0] a,
                          input logic [3:0] st, input logic [31:0] d,
                          output logic [31:0] rd, output logic er,
                          output int lat, output int jit, output int hs);
        int k;
        rd = 32'h0; er = 1'b0; lat = -1; jit = 0; hs = 0;
        bus.req = 1'b1; bus.wr = w; bus.size = 2'(sz);
        bus.addr = a; bus.wstrb = st; bus.wdata = d;
        k = 0;
        while (!bus.addr_ok && k < 30) begin
            @(negedge clk);
            k++;
        end
        if (!bus.addr_ok) begin
            n_tests++; n_fail++;
            $display("FAIL addr_ok_timeout addr=%h", a);
            bus.req = 1'b0;
            return;
        end
        jit = exp_jit(m_lfsr);
        hs = cyc;
        @(posedge clk);
        #1;
        bus.req = 1'b0; bus.wr = $urandom; bus.addr = $urandom;
        bus.wstrb = $urandom; bus.wdata = $urandom; bus.size = $urandom;
        k = 0;
        while (k < 40) begin
            @(negedge clk);
            k++;
            if (bus.data_ok) break;
        end
        if (!bus.data_ok) begin
            n_tests++; n_fail++;
            $display("FAIL data_ok_timeout addr=%h", a);
            return;
        end
        lat = k; rd = bus.rdata; er = bus.err;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus.addr_ok !== 1'b0) begin n_fail++; $display("FAIL rst_addr_ok got=%b exp=0", bus.addr_ok); end
        n_tests++;
        if (bus.data_ok !== 1'b0) begin n_fail++; $display("FAIL rst_data_ok got=%b exp=0", bus.data_ok); end
        n_tests++;
        if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got=%h exp=0", bus.rdata); end
        n_tests++;
        if (bus.err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b exp=0", bus.err); end
        resetn = 1'b1;
        n_tests++;
        if (bus.addr_ok !== 1'b0) begin n_fail++; $display("FAIL rel_addr_ok_early got=%b exp=0", bus.addr_ok); end
        @(negedge clk);
        n_tests++;
        if (bus.addr_ok !== 1'b1) begin n_fail++; $display("FAIL rel_addr_ok got=%b exp=1", bus.addr_ok); end
    endtask

    task automatic test_word_rw;
        logic [31:0] rd; logic er; int lat, jit, hs;
        do_txn(1'b1, 2, 32'h10, 4'hF, 32'hDEADBEEF, rd, er, lat, jit, hs);
        m_mem[4] = 32'hDEADBEEF;
        n_tests++;
        if (lat !== LAT + jit) begin n_fail++; $display("FAIL wr_latency got=%0d exp=%0d", lat, LAT + jit); end
        n_tests++;
        if (er !== 1'b0 || rd !== 32'h0) begin n_fail++; $display("FAIL wr_resp got=%b/%h exp=0/0", er, rd); end
        @(negedge clk);
        n_tests++;
        if (bus.data_ok !== 1'b0 || bus.addr_ok !== 1'b1) begin
            n_fail++; $display("FAIL one_cycle_resp got=%b/%b exp=0/1", bus.data_ok, bus.addr_ok);
        end
        do_txn(1'b0, 2, 32'h10, 4'h0, 32'h0, rd, er, lat, jit, hs);
        n_tests++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_fail++; $display("FAIL rd_word got=%h/%b exp=deadbeef/0", rd, er); end
    endtask

    task automatic test_byte_write;
        logic [31:0] rd; logic er; int lat, jit, hs;
        do_txn(1'b1, 0, 32'h11, 4'h2, 32'h0000_5500, rd, er, lat, jit, hs);
        m_mem[4] = 32'hDEAD55EF;
        n_tests++;
        if (er !== 1'b0) begin n_fail++; $display("FAIL byte_wr_err got=%b exp=0", er); end
        do_txn(1'b0, 2, 32'h10, 4'h0, 32'h0, rd, er, lat, jit, hs);
        n_tests++;
        if (rd !== 32'hDEAD55EF) begin n_fail++; $display("FAIL byte_rd got=%h exp=dead55ef", rd); end
    endtask

    task automatic test_errors;
        logic [31:0] rd; logic er; int lat, jit, hs;
        do_txn(1'b1, 2, 32'h0, 4'hF, 32'h12345678, rd, er, lat, jit, hs);
        m_mem[0] = 32'h12345678;
        do_txn(1'b0, 2, 32'h12, 4'h0, 32'h0, rd, er, lat, jit, hs);
        n_tests++;
        if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL misalign_word got=%b/%h exp=1/0", er, rd); end
        do_txn(1'b0, 1, 32'h13, 4'h0, 32'h0, rd, er, lat, jit, hs);
        n_tests++;
        if (er !== 1'b1) begin n_fail++; $display("FAIL misalign_half got=%b exp=1", er); end
        do_txn(1'b0, 3, 32'h10, 4'h0, 32'h0, rd, er, lat, jit, hs);
        n_tests++;
        if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL size3 got=%b/%h exp=1/0", er, rd); end
        do_txn(1'b1, 2, 32'h1000, 4'hF, 32'hFFFFFFFF, rd, er, lat, jit, hs);
        n_tests++;
        if (er !== 1'b1) begin n_fail++; $display("FAIL range_wr got=%b exp=1", er); end
        do_txn(1'b1, 2, 32'h0, 4'h0, 32'hFFFFFFFF, rd, er, lat, jit, hs);
        n_tests++;
        if (er !== 1'b0) begin n_fail++; $display("FAIL zero_strb_err got=%b exp=0", er); end
        do_txn(1'b0, 2, 32'h0, 4'h0, 32'h0, rd, er, lat, jit, hs);
        n_tests++;
        if (rd !== 32'h12345678 || er !== 1'b0) begin n_fail++; $display("FAIL word0_kept got=%h exp=12345678", rd); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; logic er; int lat, jit, hs, k;
        do_txn(1'b1, 2, 32'h20, 4'hF, 32'hA5A50F0F, rd, er, lat, jit, hs);
        m_mem[8] = 32'hA5A50F0F;
        bus.req = 1'b1; bus.wr = 1'b1; bus.size = 2'd2;
        bus.addr = 32'h20; bus.wstrb = 4'hF; bus.wdata = 32'h11112222;
        k = 0;
        while (!bus.addr_ok && k < 30) begin @(negedge clk); k++; end
        @(posedge clk);
        #1 bus.req = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.data_ok !== 1'b0) begin n_fail++; $display("FAIL rst_mid_data_ok got=%b exp=0", bus.data_ok); end
        end
        resetn = 1'b1;
        @(negedge clk);
        do_txn(1'b0, 2, 32'h20, 4'h0, 32'h0, rd, er, lat, jit, hs);
        n_tests++;
        if (rd !== 32'hA5A50F0F) begin n_fail++; $display("FAIL rst_mid_kept got=%h exp=a5a50f0f", rd); end
    endtask

    task automatic test_random;
        logic [31:0] rd, a, d, er_rd; logic er, w, e_err; logic [3:0] st;
        int lat, jit, hs, idx, sz;
        for (int i = 0; i < 64; i++) begin
            d = $urandom;
            do_txn(1'b1, 2, BASE + 32'(i * 4), 4'hF, d, rd, er, lat, jit, hs);
            m_mem[i] = d;
        end
        for (int i = 0; i < 80; i++) begin
            idx = $urandom_range(0, 63);
            sz = $urandom_range(0, 3);
            a = BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = BASE + 32'h1000 + 32'($urandom_range(0, 32'hFFFF));
            w = $urandom; st = $urandom; d = $urandom;
            e_err = ref_err(sz, a);
            er_rd = 32'h0;
            if (!e_err && !w) er_rd = m_mem[idx];
            do_txn(w, sz, a, st, d, rd, er, lat, jit, hs);
            if (!e_err && w) begin
                for (int b = 0; b < 4; b++)
                    if (st[b]) m_mem[idx][8*b +: 8] = d[8*b +: 8];
            end
            n_tests++;
            if (rd !== er_rd || er !== e_err || lat !== LAT + jit) begin
                n_fail++;
                $display("FAIL rand_op a=%h wr=%b sz=%0d got=%h/%b/%0d exp=%h/%b/%0d",
                         a, w, sz, rd, er, lat, er_rd, e_err, LAT + jit);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd; logic er; int lat, jit, hs, idx, p_hs, p_lat;
        p_hs = 0; p_lat = 0;
        for (int i = 0; i < 16; i++) begin
            idx = $urandom_range(0, 63);
            do_txn(1'b0, 2, BASE + 32'(idx * 4), 4'h0, 32'h0, rd, er, lat, jit, hs);
            n_tests++;
            if (lat !== LAT + jit || lat < LAT || lat > LAT + 3) begin
                n_fail++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, LAT + jit);
            end
            n_tests++;
            if (rd !== m_mem[idx]) begin n_fail++; $display("FAIL b2b_rdata got=%h exp=%h", rd, m_mem[idx]); end
            if (i > 0) begin
                n_tests++;
                if (hs - p_hs !== p_lat + 1) begin
                    n_fail++; $display("FAIL b2b_gap got=%0d exp=%0d", hs - p_hs, p_lat + 1);
                end
            end
            p_hs = hs; p_lat = lat;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bus.req = 1'b0; bus.wr = 1'b0; bus.size = 2'd0;
        bus.addr = 32'h0; bus.wstrb = 4'h0; bus.wdata = 32'h0;
        test_reset();
        test_word_rw();
        test_byte_write();
        test_errors();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/phys_mem_responder.md
# phys_mem_responder

Responder end of the core's data-side memory request interface: accepts physically addressed requests (kseg0/kseg1 already stripped to physical form upstream), services them from an internal byte-enabled word array, and returns a one-cycle response after a fixed, optionally jittered, latency. It sits between the core's load/store request port and on-chip memory. It is the system-side counterpart that initiator-side address translation feeds, and the reference target for core bring-up and verification.

## Interface
- MEM_WORDS, 1024: number of 32-bit words; power of two, ≥ 16.
- BASE_ADDR, 32'h0000_0000: physical byte address of word 0; MEM_WORDS*4 aligned.
- LATENCY, 2: cycles from request acceptance to data_ok; legal 1..15.
- clk  in  1  sole clock, rising edge.
- resetn  in  1  synchronous, active-low reset.
- req  in  1  request valid.
- wr  in  1  1 = write, 0 = read.
- size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- addr  in  32  physical byte address.
- wstrb  in  4  byte lanes to write; ignored on reads.
- wdata  in  32  write data, lane-aligned.
- addr_ok  out  1  responder can accept; handshake = req & addr_ok.
- data_ok  out  1  one-cycle response strobe.
- rdata  out  32  aligned read word, valid with data_ok.
- err  out  1  response error, valid with data_ok.

## Operation
- One transaction outstanding. States: IDLE, WAIT, RESP.
- IDLE: addr_ok = 1. On handshake, latch wr, size, addr, wstrb, wdata and error status. Load the wait counter with LATENCY-1 plus jitter. Go to WAIT, or go straight to RESP if the loaded value is 0.
- WAIT: addr_ok = 0. Decrement the counter. Go to RESP when it reaches 0.
- RESP: data_ok = 1 for exactly one cycle, then go to IDLE. addr_ok stays 0 in RESP.
- Error conditions: size == 3; size == 1 with addr[0] = 1; size == 2 with addr[1:0] ≠ 0; offset = addr - BASE_ADDR with offset ≥ MEM_WORDS*4 (unsigned).
- On error: err = 1 and rdata = 0 at response; no memory write.
- Read, no error: rdata = mem[offset[..:2]] as a full word, sampled in the RESP-entry cycle. The core extracts bytes.
- Write, no error: bytes with wstrb[i] = 1 are written in the RESP-entry cycle; rdata = 0.
- wstrb = 0 on a write is legal: no bytes change, err = 0.
- wstrb inconsistent with size is not checked; wstrb governs.
- A read issued immediately after a write to the same word returns the new data.

## Timing
- Reset values: addr_ok = 0, data_ok = 0, rdata = 0, err = 0, state = IDLE, counter = 0. Memory contents are not reset.
- addr_ok rises 1 cycle after resetn deasserts.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Handshake at edge T → data_ok high in cycle T+LATENCY (+ jitter). The next handshake is possible at T+LATENCY+1 at the earliest.
- req held with addr_ok = 0 is ignored; the requester must hold it.
- resetn low mid-transaction: the transaction is dropped. No data_ok, no write (the commit point is RESP entry). Outputs return to reset values on the next edge.
- Back-to-back throughput: one transaction per LATENCY+1 cycles.

## Configuration
- MEM_RESP_JITTER_EN defined: a 4-bit LFSR (x^4+x^3+1, reset seed 4'b1001) steps every cycle. At each handshake, lfsr[1:0] (0..3) extra wait cycles are added to LATENCY-1.
- MEM_RESP_JITTER_EN undefined: latency is exactly LATENCY, and the LFSR logic is absent.

## Structure
- Shared package mem_resp_pkg holds:
  - size encodings SZ_BYTE / SZ_HALF / SZ_WORD;
  - state encodings S_IDLE / S_WAIT / S_RESP;
  - LFSR_SEED.
- Sub-module byte_en_ram: MEM_WORDS × 32, 4 byte write enables, asynchronous read. Instantiated once.
- The FSM, error decode, counter and LFSR live in the top module.

## Test plan
- Reset: hold resetn = 0 for 3 cycles → all outputs 0. addr_ok = 1 exactly 1 cycle after release.
- Word write then read, LATENCY = 2:
  - write addr 0x10, wstrb 4'hF, wdata 0xDEADBEEF → data_ok at T+2, err = 0;
  - read 0x10 → rdata 0xDEADBEEF.
- Byte write: write addr 0x11, size 0, wstrb 4'h2, wdata 0x0000_5500 over 0xDEADBEEF; read 0x10 → 0xDEAD55EF.
- Errors:
  - read addr 0x12 size 2 → err = 1, rdata 0;
  - write addr 0x1000 (MEM_WORDS = 1024) → err = 1, and word 0 is unchanged.
- Reset mid-transaction: accept a write to 0x20, assert resetn = 0 in the WAIT cycle → no data_ok; after reset, read 0x20 → old value.
- Jitter: with MEM_RESP_JITTER_EN, 16 back-to-back reads → each latency lies in 2..5 and matches the LFSR model. Without the macro, every latency is 2.
